// File: rtl/pmod_acl2_spi_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : pmod_acl2_spi_responder
// Brief  : ADXL362-style SPI register responder (Pmod ACL2 far-end model)
// Rev    : 1.0 - initial release
// ============================================================================
module pmod_acl2_spi_responder #(
  parameter int unsigned c_sck_min_div = 8,
  parameter logic [7:0]  c_id_devid_ad = 8'hAD
) (
  input  logic        i_clk_40mhz,
  input  logic        i_rst_40mhz,
  input  logic        i_sck,
  input  logic        i_csn,
  input  logic        i_mosi,
  output logic        o_miso,
  output logic        o_miso_en,
  input  logic        i_sample_valid,
  input  logic [63:0] i_sample_xyzt,
  output logic        o_wr_strobe,
  output logic [5:0]  o_wr_addr,
  output logic [7:0]  o_wr_data,
  output logic        o_busy
);

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_cmd     = 3'd1;
  localparam logic [2:0] c_st_addr    = 3'd2;
  localparam logic [2:0] c_st_data_wr = 3'd3;
  localparam logic [2:0] c_st_data_rd = 3'd4;
  localparam logic [2:0] c_st_ignore  = 3'd5;

  localparam logic [7:0] c_cmd_write     = 8'h0A;
  localparam logic [7:0] c_cmd_read      = 8'h0B;
  localparam logic [7:0] c_soft_rst_code = 8'h52;
  localparam logic [5:0] c_addr_samp_lo  = 6'h0E;
  localparam logic [5:0] c_addr_samp_hi  = 6'h15;
  localparam logic [5:0] c_addr_cfg_lo   = 6'h1F;
  localparam logic [5:0] c_addr_cfg_hi   = 6'h2E;
  localparam logic [3:0] c_idx_2c        = 4'(6'h2C - 6'h1F);
  localparam logic [7:0] c_min_phase     = 8'(c_sck_min_div / 2 - 1);

  logic r_sck_s1, r_sck_s2, r_sck_d;
  logic r_csn_s1, r_csn_s2, r_csn_d;
  logic r_mosi_s1, r_mosi_s2;

  always_ff @(posedge i_clk_40mhz or posedge i_rst_40mhz) begin
    if (i_rst_40mhz) begin
      {r_sck_s1, r_sck_s2, r_sck_d} <= 3'b000;
      {r_csn_s1, r_csn_s2, r_csn_d} <= 3'b111;
      {r_mosi_s1, r_mosi_s2}        <= 2'b00;
    end else begin
      r_sck_s1  <= i_sck;
      r_sck_s2  <= r_sck_s1;
      r_sck_d   <= r_sck_s2;
      r_csn_s1  <= i_csn;
      r_csn_s2  <= r_csn_s1;
      r_csn_d   <= r_csn_s2;
      r_mosi_s1 <= i_mosi;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  logic w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;
  assign w_sck_rise = r_sck_s2 & ~r_sck_d;
  assign w_sck_fall = ~r_sck_s2 & r_sck_d;
  assign w_cs_fall  = ~r_csn_s2 & r_csn_d;
  assign w_cs_rise  = r_csn_s2 & ~r_csn_d;

  logic [2:0] r_state;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_rx;
  logic       r_is_read;
  logic [5:0] r_addr;
  logic [7:0] w_rx_byte;
  logic       w_byte_done;

  assign w_rx_byte   = {r_rx, r_mosi_s2};
  assign w_byte_done = w_sck_rise && (r_bit_cnt == 3'd7) &&
                       (r_state != c_st_idle) && (r_state != c_st_ignore);

  always_ff @(posedge i_clk_40mhz or posedge i_rst_40mhz) begin
    if (i_rst_40mhz) begin
      r_state   <= c_st_idle;
      r_bit_cnt <= 3'd0;
      r_rx      <= 7'd0;
      r_is_read <= 1'b0;
      r_addr    <= 6'd0;
    end else if (w_cs_rise) begin
      r_state   <= c_st_idle;
      r_bit_cnt <= 3'd0;
    end else if (r_state == c_st_idle) begin
      if (w_cs_fall) begin
        r_state   <= c_st_cmd;
        r_bit_cnt <= 3'd0;
      end
    end else if (w_sck_rise && (r_state != c_st_ignore)) begin
      r_rx      <= w_rx_byte[6:0];
      r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_byte_done) begin
        case (r_state)
          c_st_cmd: begin
            if (w_rx_byte == c_cmd_write) begin
              r_state   <= c_st_addr;
              r_is_read <= 1'b0;
            end else if (w_rx_byte == c_cmd_read) begin
              r_state   <= c_st_addr;
              r_is_read <= 1'b1;
            end else begin
              r_state <= c_st_ignore;
            end
          end
          // A read pre-loads reg[addr] here, so the pointer already moves on.
          c_st_addr: begin
            r_state <= r_is_read ? c_st_data_rd : c_st_data_wr;
            r_addr  <= r_is_read ? (w_rx_byte[5:0] + 6'd1) : w_rx_byte[5:0];
          end
          default: r_addr <= r_addr + 6'd1;
        endcase
      end
    end
  end

  logic [7:0] r_cfg [16];
  logic [7:0] r_samp [8];
  logic       r_soft_rst;
  logic       r_wr_strobe;
  logic [5:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic       w_wr_fire, w_cfg_wr_ok;
  logic [3:0] w_wr_idx;

  assign w_wr_fire   = w_byte_done && (r_state == c_st_data_wr);
  assign w_cfg_wr_ok = (r_addr >= c_addr_cfg_lo) && (r_addr <= c_addr_cfg_hi);
  assign w_wr_idx    = 4'(r_addr - c_addr_cfg_lo);

  always_ff @(posedge i_clk_40mhz or posedge i_rst_40mhz) begin
    if (i_rst_40mhz) begin
      for (int i = 0; i < 16; i++) r_cfg[i] <= (4'(i) == c_idx_2c) ? 8'h13 : 8'h00;
      r_soft_rst  <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= 6'd0;
      r_wr_data   <= 8'd0;
    end else begin
      r_wr_strobe <= w_wr_fire && w_cfg_wr_ok;
      r_soft_rst  <= w_wr_fire && w_cfg_wr_ok && (r_addr == c_addr_cfg_lo) &&
                     (w_rx_byte == c_soft_rst_code);
      if (r_soft_rst)
        for (int i = 0; i < 16; i++) r_cfg[i] <= (4'(i) == c_idx_2c) ? 8'h13 : 8'h00;
      if (w_wr_fire && w_cfg_wr_ok) begin
        r_cfg[w_wr_idx] <= w_rx_byte;
        r_wr_addr       <= r_addr;
        r_wr_data       <= w_rx_byte;
      end
    end
  end

  always_ff @(posedge i_clk_40mhz or posedge i_rst_40mhz) begin
    if (i_rst_40mhz) begin
      for (int k = 0; k < 8; k++) r_samp[k] <= 8'h00;
    end else if (i_sample_valid) begin
      for (int k = 0; k < 8; k++) r_samp[k] <= i_sample_xyzt[8*k +: 8];
    end
  end

  logic [5:0] w_rd_addr;
  logic [7:0] w_rd_byte;
  logic       w_tx_load;

  assign w_rd_addr = (r_state == c_st_addr) ? w_rx_byte[5:0] : r_addr;
  assign w_tx_load = w_byte_done &&
                     (((r_state == c_st_addr) && r_is_read) || (r_state == c_st_data_rd));

  always_comb begin
    w_rd_byte = 8'h00;
    if (w_rd_addr == 6'h00)      w_rd_byte = c_id_devid_ad;
    else if (w_rd_addr == 6'h01) w_rd_byte = 8'h1D;
    else if (w_rd_addr == 6'h02) w_rd_byte = 8'hF2;
    else if (w_rd_addr == 6'h03) w_rd_byte = 8'h01;
    else if ((w_rd_addr >= c_addr_samp_lo) && (w_rd_addr <= c_addr_samp_hi))
      w_rd_byte = r_samp[3'(w_rd_addr - c_addr_samp_lo)];
    else if ((w_rd_addr >= c_addr_cfg_lo) && (w_rd_addr <= c_addr_cfg_hi))
      w_rd_byte = r_cfg[4'(w_rd_addr - c_addr_cfg_lo)];
  end

  logic [7:0] r_tx;
  logic       r_miso, r_miso_en;

  always_ff @(posedge i_clk_40mhz or posedge i_rst_40mhz) begin
    if (i_rst_40mhz) begin
      r_tx      <= 8'h00;
      r_miso    <= 1'b0;
      r_miso_en <= 1'b0;
    end else begin
      r_miso_en <= ~r_csn_d;
      if (w_tx_load)
        r_tx <= w_rd_byte;
      else if ((r_state == c_st_data_rd) && w_sck_fall)
        r_tx <= {r_tx[6:0], 1'b0};
      if ((r_state != c_st_data_rd) || w_cs_rise)
        r_miso <= 1'b0;
      else if (w_sck_fall)
        r_miso <= r_tx[7];
    end
  end

  // SCK phase monitor: flags an SCK half-period shorter than c_sck_min_div/2 cycles.
  logic [7:0] r_phase_cnt;
  always_ff @(posedge i_clk_40mhz or posedge i_rst_40mhz) begin
    if (i_rst_40mhz)                    r_phase_cnt <= 8'hFF;
    else if (w_sck_rise || w_sck_fall)  r_phase_cnt <= 8'h00;
    else if (r_phase_cnt != 8'hFF)      r_phase_cnt <= r_phase_cnt + 8'd1;
  end

  always @(posedge i_clk_40mhz) begin
    if (!i_rst_40mhz && !r_csn_s2 && (w_sck_rise || w_sck_fall))
      assert (r_phase_cnt >= c_min_phase) else $error("SCK phase below minimum");
  end

  assign o_miso      = r_miso;
  assign o_miso_en   = r_miso_en;
  assign o_wr_strobe = r_wr_strobe;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_busy      = (r_state != c_st_idle);

endmodule
`default_nettype wire
